// File: rtl/div_if.sv
// div_if: EX-stage divide request/response bundle between the pipeline (master) and div_unit (slave).
interface div_if;
   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        annul;
   logic [31:0] result_hi;
   logic [31:0] result_lo;
   logic        ready;
   logic        stall_req;
   modport master (output start, signed_op, dividend, divisor, annul,
                   input result_hi, result_lo, ready, stall_req);
   modport slave  (input start, signed_op, dividend, divisor, annul,
                   output result_hi, result_lo, ready, stall_req);
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned restoring radix-2 divider, one quotient bit per cycle.
// DIV_ZERO_SHORTCUT_EN: a zero divisor skips the iterations and completes one cycle after start.
module div_unit (
   input logic   clk,
   input logic   rst,
   div_if.slave  bus
);
`ifdef DIV_ZERO_SHORTCUT_EN
   localparam bit SHORTCUT = 1'b1;
`else
   localparam bit SHORTCUT = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      state, state_n;
   logic [4:0]  cnt;
   logic [63:0] acc, acc_n;
   logic [32:0] diff;
   logic [31:0] dvs, a_mag, b_mag, hi, lo;
   logic        neg_q, neg_r, rdy, zero_div, accept;
   assign zero_div = bus.divisor == 32'd0;
   assign accept   = state == IDLE && bus.start && !bus.annul;
   assign a_mag    = (bus.signed_op & bus.dividend[31]) ? -bus.dividend : bus.dividend;
   assign b_mag    = (bus.signed_op & bus.divisor[31]) ? -bus.divisor : bus.divisor;
   // acc holds {remainder, quotient}; the trial subtract uses the 33 bits above the shift point
   assign diff  = acc[63:31] - {1'b0, dvs};
   assign acc_n = diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (bus.annul) state_n = IDLE;
      else if (state == IDLE && bus.start) state_n = (SHORTCUT && zero_div) ? DONE : BUSY;
      else if (state == BUSY && cnt == 5'd31) state_n = DONE;
      else if (state == DONE) state_n = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt   <= '0;
         acc   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         rdy   <= 1'b0;
      end else begin
         rdy <= state_n == DONE;
         if (accept) begin
            cnt   <= '0;
            acc   <= {32'd0, a_mag};
            dvs   <= b_mag;
            // divide by zero yields an all-ones quotient, so suppress its negation
            neg_q <= bus.signed_op & (bus.dividend[31] ^ bus.divisor[31]) & ~zero_div;
            neg_r <= bus.signed_op & bus.dividend[31];
         end
         if (state == BUSY) begin
            cnt <= cnt + 5'd1;
            acc <= acc_n;
         end
         if (state == BUSY && state_n == DONE) begin
            lo <= neg_q ? -acc_n[31:0] : acc_n[31:0];
            hi <= neg_r ? -acc_n[63:32] : acc_n[63:32];
         end
         if (state == IDLE && state_n == DONE) begin
            lo <= '1;
            hi <= bus.dividend;
         end
      end
   assign bus.result_hi = hi;
   assign bus.result_lo = lo;
   assign bus.ready     = rdy;
   assign bus.stall_req = bus.start & ~rdy;
endmodule
